// File: rtl/chunked_serial_adder.sv
// rtl/chunked_serial_adder.sv - multi-cycle adder, CHUNK bits per clock, LSB chunk first
// Optional subtract mode is enabled by defining ADDER_SUB_EN.
module chunked_serial_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryin,
`ifdef ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state, next_state;
  logic             accept;
  logic [WIDTH-1:0] la, lb, acc, acc_next;
  logic [WIDTH-1:0] b_in;
  logic             c_in;
  logic             carry;
  logic [KW-1:0]    k;
  logic             last;
  logic [CHUNK-1:0] a_ch, b_ch;
  logic [CHUNK:0]   ch_res;

`ifdef ADDER_SUB_EN
  // a - b is folded into a + ~b + 1 at latch time so the datapath stays add-only
  assign b_in = sub ? ~b : b;
  assign c_in = sub ? 1'b1 : carryin;
`else
  assign b_in = b;
  assign c_in = carryin;
`endif

  assign last = (k == KW'(N - 1));

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          next_state = S_RUN;
          accept     = 1'b1;
        end
      end
      S_RUN: begin
        if (last) next_state = S_DONE;
      end
      S_DONE: begin
        if (start) begin
          next_state = S_RUN;
          accept     = 1'b1;
        end else begin
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    a_ch     = la[int'(k) * CHUNK +: CHUNK];
    b_ch     = lb[int'(k) * CHUNK +: CHUNK];
    ch_res   = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, carry};
    acc_next = acc;
    acc_next[int'(k) * CHUNK +: CHUNK] = ch_res[CHUNK-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      la       <= '0;
      lb       <= '0;
      acc      <= '0;
      carry    <= 1'b0;
      k        <= '0;
      sum      <= '0;
      carryout <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= (next_state == S_RUN);
      done  <= (next_state == S_DONE);
      if (accept) begin
        la    <= a;
        lb    <= b_in;
        carry <= c_in;
        k     <= '0;
      end else if (state == S_RUN) begin
        acc   <= acc_next;
        carry <= ch_res[CHUNK];
        k     <= k + 1'b1;
        if (last) begin
          sum      <= acc_next;
          carryout <= ch_res[CHUNK];
          // carry into the MSB is recovered as a ^ b ^ sum at that bit
          overflow <= la[WIDTH-1] ^ lb[WIDTH-1] ^ acc_next[WIDTH-1] ^ ch_res[CHUNK];
        end
      end
    end
  end

endmodule

// File: tb/tb_chunked_serial_adder.sv
// tb/tb_chunked_serial_adder.sv - directed self-checking bench for chunked_serial_adder
module tb_chunked_serial_adder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       carryin = 1'b0;
  logic       sub = 1'b0;
  logic       busy, done, carryout, overflow;
  logic [7:0] sum;

  int checks = 0;
  int passed = 0;

  chunked_serial_adder #(.WIDTH(8), .CHUNK(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a        (a),
    .b        (b),
    .carryin  (carryin),
`ifdef ADDER_SUB_EN
    .sub      (sub),
`endif
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .carryout (carryout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Drive operands with start high at a falling edge, then wait for the accepting edge E0.
  task automatic kick(input logic [7:0] ta, input logic [7:0] tb_, input logic tc, input logic ts);
    @(negedge clk);
    a = ta; b = tb_; carryin = tc; sub = ts; start = 1'b1;
    @(posedge clk);
  endtask

  // Runs one isolated op: checks busy for N=4 cycles, then the done cycle results.
  task automatic test_op(input string name, input logic [7:0] ta, input logic [7:0] tb_,
                         input logic tc, input logic ts,
                         input logic [7:0] es, input logic ec, input logic eo);
    kick(ta, tb_, tc, ts);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 1) begin start = 1'b0; a = 8'hA5; b = 8'h5A; carryin = ~tc; sub = ~ts; end
      checks++;
      if (busy !== 1'b1 || done !== 1'b0)
        $display("FAIL %s busy cycle %0d: busy=%b done=%b, required busy=1 done=0", name, i, busy, done);
      else passed++;
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || sum !== es || carryout !== ec || overflow !== eo)
      $display("FAIL %s result: done=%b busy=%b sum=%h co=%b ov=%b, required done=1 busy=0 sum=%h co=%b ov=%b",
               name, done, busy, sum, carryout, overflow, es, ec, eo);
    else passed++;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || sum !== es)
      $display("FAIL %s after done: done=%b busy=%b sum=%h, required 0 0 %h", name, done, busy, sum, es);
    else passed++;
  endtask

  task automatic test_reset;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || carryout !== 1'b0 || overflow !== 1'b0)
      $display("FAIL reset_async: busy=%b done=%b sum=%h co=%b ov=%b, required all 0",
               busy, done, sum, carryout, overflow);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_back_to_back;
    kick(8'h01, 8'h02, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 2) begin a = 8'h10; b = 8'h20; end
      checks++;
      if (busy !== 1'b1 || done !== 1'b0)
        $display("FAIL b2b first busy %0d: busy=%b done=%b, required 1 0", i, busy, done);
      else passed++;
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || sum !== 8'h03)
      $display("FAIL b2b first result: done=%b sum=%h, required done=1 sum=03", done, sum);
    else passed++;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || sum !== 8'h03)
        $display("FAIL b2b second run %0d: busy=%b done=%b sum=%h, required 1 0 03", i, busy, done, sum);
      else passed++;
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || sum !== 8'h30 || carryout !== 1'b0 || overflow !== 1'b0)
      $display("FAIL b2b second result: done=%b sum=%h co=%b ov=%b, required 1 30 0 0",
               done, sum, carryout, overflow);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_mid_reset;
    int saw_done;
    kick(8'h55, 8'h11, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || carryout !== 1'b0 || overflow !== 1'b0)
      $display("FAIL mid_reset clear: busy=%b done=%b sum=%h co=%b ov=%b, required all 0",
               busy, done, sum, carryout, overflow);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
    saw_done = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) saw_done++;
    end
    checks++;
    if (saw_done != 0)
      $display("FAIL mid_reset aborted op: active cycles=%0d, required 0", saw_done);
    else passed++;
    test_op("after_reset", 8'h03, 8'h04, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0);
  endtask

  task automatic test_first_edge_accept;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; a = 8'h21; b = 8'h12; carryin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1)
      $display("FAIL first_edge_accept: busy=%b, required 1", busy);
    else passed++;
    repeat (4) @(negedge clk);
    checks++;
    if (done !== 1'b1 || sum !== 8'h33)
      $display("FAIL first_edge_result: done=%b sum=%h, required 1 33", done, sum);
    else passed++;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_op("signed_overflow", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    test_op("unsigned_wrap", 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0);
    test_back_to_back();
    test_mid_reset();
    test_first_edge_accept();
`ifdef ADDER_SUB_EN
    test_op("sub_borrow", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
    test_op("sub_overflow", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
    test_op("sub0_add", 8'h40, 8'h40, 1'b1, 1'b0, 8'h81, 1'b0, 1'b1);
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
